// File: rtl/ccff_frame_loader_if.sv
// Bit-serial configuration bus between a frame source and ccff_frame_loader.
// The master modport is the source side; the slave modport is the loader side.
interface ccff_frame_loader_if #(
    parameter int FRAME_BITS = 16
);
    logic                  ccff_head;
    logic                  ccff_valid;
    logic                  ccff_ready;
    logic                  cfg_abort;
    logic                  ccff_tail;
    logic [FRAME_BITS-1:0] mem_out;
    logic [FRAME_BITS-1:0] mem_outb;
    logic                  cfg_done;
    logic                  cfg_err;

    modport master (
        output ccff_head,
        output ccff_valid,
        output cfg_abort,
        input  ccff_ready,
        input  ccff_tail,
        input  mem_out,
        input  mem_outb,
        input  cfg_done,
        input  cfg_err
    );

    modport slave (
        input  ccff_head,
        input  ccff_valid,
        input  cfg_abort,
        output ccff_ready,
        output ccff_tail,
        output mem_out,
        output mem_outb,
        output cfg_done,
        output cfg_err
    );
endinterface

// File: rtl/ccff_frame_loader.sv
// Serial configuration-frame loader: shifts a parity-protected frame and commits
// it atomically to complementary TGATE select outputs; sr MSB doubles as the chain tail.
module ccff_frame_loader #(
    parameter int FRAME_BITS = 16
) (
    input  logic               prog_clk,
    input  logic               pReset,
    ccff_frame_loader_if.slave bus
);
    localparam int CNT_W = $clog2(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        ST_SHIFT  = 2'd0,
        ST_PARITY = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_par;
    logic                  r_bad;
    logic [FRAME_BITS-1:0] r_sr;
    logic [FRAME_BITS-1:0] r_mem;
    logic [FRAME_BITS-1:0] r_memb;
    logic                  r_done;
    logic                  r_err;

    logic                  w_ready;
    logic                  w_abort;
    logic                  w_xfer;
    logic                  w_last_data;

    // Abort is ignored in COMMIT so an in-flight commit always completes.
    assign w_ready     = ~pReset & (r_state != ST_COMMIT);
    assign w_abort     = bus.cfg_abort & (r_state != ST_COMMIT);
    assign w_xfer      = bus.ccff_valid & w_ready & ~w_abort;
    assign w_last_data = (r_cnt == CNT_W'(FRAME_BITS - 1));

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            r_state <= ST_SHIFT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_SHIFT: begin
                if (w_abort) begin
                    w_next = ST_SHIFT;
                end else if (w_xfer && w_last_data) begin
                    w_next = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (w_abort) begin
                    w_next = ST_SHIFT;
                end else if (w_xfer) begin
                    w_next = ST_COMMIT;
                end
            end
            ST_COMMIT: w_next = ST_SHIFT;
            default:   w_next = ST_SHIFT;
        endcase
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            r_cnt  <= '0;
            r_par  <= 1'b0;
            r_bad  <= 1'b0;
            r_sr   <= '0;
            r_mem  <= '0;
            r_memb <= '1;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_SHIFT: begin
                    if (w_abort) begin
                        r_cnt <= '0;
                        r_par <= 1'b0;
                    end else if (w_xfer) begin
                        r_sr  <= {r_sr[FRAME_BITS-2:0], bus.ccff_head};
                        r_cnt <= r_cnt + CNT_W'(1);
                        r_par <= r_par ^ bus.ccff_head;
                    end
                end
                ST_PARITY: begin
                    if (w_abort) begin
                        r_cnt <= '0;
                        r_par <= 1'b0;
                    end else if (w_xfer) begin
                        r_bad <= r_par ^ bus.ccff_head;
                    end
                end
                ST_COMMIT: begin
                    // mem_out and mem_outb share one edge so the select pair never overlaps.
                    if (!r_bad) begin
                        r_mem  <= r_sr;
                        r_memb <= ~r_sr;
                        r_done <= 1'b1;
                        r_err  <= 1'b0;
                    end else begin
                        r_err  <= 1'b1;
                    end
                    r_cnt <= '0;
                    r_par <= 1'b0;
                end
                default: begin
                    r_cnt <= '0;
                    r_par <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ccff_ready = w_ready;
    assign bus.ccff_tail  = r_sr[FRAME_BITS-1];
    assign bus.mem_out    = r_mem;
    assign bus.mem_outb   = r_memb;
    assign bus.cfg_done   = r_done;
    assign bus.cfg_err    = r_err;
endmodule
